// File: rtl/bbox_pkg.sv
// bbox_pkg: shared types and constants for the bounding-box crop engine.
//   state_e          - controller state encoding (also exported on dbg_state)
//   coord_t          - x/y pixel coordinate, wide enough for frames up to 4096 px per side
//   BG_VALUE_DEFAULT - default background pixel value
//   cnt_width()      - bits needed to hold a count 0..n inclusive
package bbox_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SCAN       = 3'd1,
    ST_SCAN_DRAIN = 3'd2,
    ST_COPY       = 3'd3,
    ST_COPY_DRAIN = 3'd4,
    ST_DONE       = 3'd5
  } state_e;

  localparam int unsigned COORD_W = 12;
  typedef logic [COORD_W-1:0] coord_t;

  localparam logic [7:0] BG_VALUE_DEFAULT = 8'hFF;

  // Width of a counter that must represent the value n itself (e.g. a box
  // width equal to the full frame width).
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/bbox_tracker.sv
// bbox_tracker: min/max accumulator for the foreground bounding box.
// Each cycle with valid_i=1 and fg_i=1 folds (x_i, y_i) into the box; the
// registered box is visible the following cycle. clear_i (or reset) returns
// the box to its empty form: min at the far corner, max at the origin.
// Ports:
//   clk_i, rst_i      - clock, synchronous active-high reset
//   clear_i           - reinitialise the box (takes priority over valid_i)
//   valid_i, fg_i     - sample qualifier and foreground flag
//   x_i, y_i          - sample coordinates
//   min_x_o..max_y_o  - current box corners
//   found_o           - at least one foreground sample since the last clear
module bbox_tracker
  import bbox_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   clear_i,
  input  logic   valid_i,
  input  logic   fg_i,
  input  coord_t x_i,
  input  coord_t y_i,
  output coord_t min_x_o,
  output coord_t min_y_o,
  output coord_t max_x_o,
  output coord_t max_y_o,
  output logic   found_o
);

  localparam coord_t MIN_X_INIT = coord_t'(IMG_W - 1);
  localparam coord_t MIN_Y_INIT = coord_t'(IMG_H - 1);

  coord_t min_x_q, min_x_d;
  coord_t min_y_q, min_y_d;
  coord_t max_x_q, max_x_d;
  coord_t max_y_q, max_y_d;
  logic   found_q, found_d;

  always_comb begin
    min_x_d = min_x_q;
    min_y_d = min_y_q;
    max_x_d = max_x_q;
    max_y_d = max_y_q;
    found_d = found_q;
    if (clear_i) begin
      min_x_d = MIN_X_INIT;
      min_y_d = MIN_Y_INIT;
      max_x_d = '0;
      max_y_d = '0;
      found_d = 1'b0;
    end else if (valid_i && fg_i) begin
      if (x_i < min_x_q) min_x_d = x_i;
      if (y_i < min_y_q) min_y_d = y_i;
      if (x_i > max_x_q) max_x_d = x_i;
      if (y_i > max_y_q) max_y_d = y_i;
      found_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      min_x_q <= MIN_X_INIT;
      min_y_q <= MIN_Y_INIT;
      max_x_q <= '0;
      max_y_q <= '0;
      found_q <= 1'b0;
    end else begin
      min_x_q <= min_x_d;
      min_y_q <= min_y_d;
      max_x_q <= max_x_d;
      max_y_q <= max_y_d;
      found_q <= found_d;
    end
  end

  assign min_x_o = min_x_q;
  assign min_y_o = min_y_q;
  assign max_x_o = max_x_q;
  assign max_y_o = max_y_q;
  assign found_o = found_q;

endmodule

// File: rtl/bbox_crop_engine.sv
// bbox_crop_engine: scans a grayscale frame for its non-background bounding
// box, then copies that box row-major into a write memory starting at 0.
//
// Protocol: start is a one-cycle request honoured only in IDLE. busy is high
// from the cycle after acceptance until done rises; done is a level that
// holds (with empty, crop_w, crop_h, out_len stable) until reset. Any start
// outside IDLE is ignored, so a new run needs a reset first.
//
// Memory timing: rd_data carries the word for the rd_addr of the previous
// cycle. A copied word is presented on wr_addr/wr_data/wr_en in the cycle its
// read data returns, so writes trail reads by exactly one cycle.
//
// Build option BBOX_ROW_PAD4_EN: each cropped row is followed by zero words
// until the row holds a multiple of 4 words; pad words take COPY cycles of
// their own (no read issued) and are counted in out_len.
//
// Ports:
//   CLOCK_50, reset        - clock, synchronous active-high reset
//   start                  - run request
//   rd_addr / rd_data      - frame read port (row-major y*IMG_W+x), 0 when idle
//   wr_addr/wr_data/wr_en  - cropped image write port
//   busy, done, empty      - run status; empty=1 means no foreground found
//   crop_w, crop_h         - box size (0 when empty), valid with done
//   out_len                - number of words written
//   dbg_state              - current controller state (state_e encoding)
module bbox_crop_engine
  import bbox_pkg::*;
#(
  parameter int               IMG_W    = 64,
  parameter int               IMG_H    = 64,
  parameter int               PIX_W    = 8,
  parameter logic [PIX_W-1:0] BG_VALUE = PIX_W'(BG_VALUE_DEFAULT),
  parameter int               ADDR_W   = $clog2(IMG_W * IMG_H)
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          start,
  output logic [ADDR_W-1:0]             rd_addr,
  input  logic [PIX_W-1:0]              rd_data,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [PIX_W-1:0]              wr_data,
  output logic                          wr_en,
  output logic                          busy,
  output logic                          done,
  output logic                          empty,
  output logic [cnt_width(IMG_W)-1:0]   crop_w,
  output logic [cnt_width(IMG_H)-1:0]   crop_h,
  output logic [ADDR_W:0]               out_len,
  output logic [2:0]                    dbg_state
);

  localparam int     CW_W   = cnt_width(IMG_W);
  localparam int     CH_W   = cnt_width(IMG_H);
  localparam coord_t LAST_X = coord_t'(IMG_W - 1);
  localparam coord_t LAST_Y = coord_t'(IMG_H - 1);

  state_e state_q, state_d;

  // Scan address generator and its one-cycle-delayed copy that lines up with
  // rd_data for the tracker.
  logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
  coord_t            scan_x_q, scan_x_d;
  coord_t            scan_y_q, scan_y_d;
  logic              pvld_q;
  coord_t            px_q, py_q;

  // Copy walk, as offsets from the box origin.
  coord_t ox_q, ox_d;
  coord_t oy_q, oy_d;

  // Write stage and word counter.
  logic            wvld_q, wvld_d;
  logic [ADDR_W:0] wr_cnt_q, wr_cnt_d;
  logic            wr_is_pad;

`ifdef BBOX_ROW_PAD4_EN
  logic       in_pad_q, in_pad_d;
  logic [1:0] pad_left_q, pad_left_d;
  logic       wpad_q, wpad_d;
  logic [1:0] row_pads;
`endif

  logic              row_done;
  logic              track_clear;
  logic              fg;
  logic              found;
  logic              found_now;
  coord_t            min_x, min_y, max_x, max_y;
  coord_t            bw, bh;
  logic [ADDR_W-1:0] copy_addr;
  logic [ADDR_W-1:0] rd_addr_c;

  bbox_tracker #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) u_tracker (
    .clk_i   (CLOCK_50),
    .rst_i   (reset),
    .clear_i (track_clear),
    .valid_i (pvld_q),
    .fg_i    (fg),
    .x_i     (px_q),
    .y_i     (py_q),
    .min_x_o (min_x),
    .min_y_o (min_y),
    .max_x_o (max_x),
    .max_y_o (max_y),
    .found_o (found)
  );

  assign fg = (rd_data != BG_VALUE);

  // The final scanned datum is still in flight during SCAN_DRAIN, so the
  // empty/non-empty decision has to include it combinationally.
  assign found_now = found | (pvld_q & fg);

  // Box extent minus one; only meaningful once found is set.
  assign bw = max_x - min_x;
  assign bh = max_y - min_y;

  assign copy_addr = ADDR_W'((int'(min_y) + int'(oy_q)) * IMG_W + int'(min_x) + int'(ox_q));

`ifdef BBOX_ROW_PAD4_EN
  // Row length is bw+1; the pads needed to reach a multiple of 4 are
  // -(bw+1) mod 4, which is simply the low two bits of ~bw.
  assign row_pads  = ~bw[1:0];
  assign wr_is_pad = wpad_q;
`else
  assign wr_is_pad = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    scan_addr_d = scan_addr_q;
    scan_x_d    = scan_x_q;
    scan_y_d    = scan_y_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    wvld_d      = 1'b0;
    wr_cnt_d    = wr_cnt_q + {{ADDR_W{1'b0}}, wvld_q};
    rd_addr_c   = '0;
    track_clear = 1'b0;
    row_done    = 1'b0;
`ifdef BBOX_ROW_PAD4_EN
    in_pad_d    = in_pad_q;
    pad_left_d  = pad_left_q;
    wpad_d      = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_SCAN;
          track_clear = 1'b1;
          scan_addr_d = '0;
          scan_x_d    = '0;
          scan_y_d    = '0;
          ox_d        = '0;
          oy_d        = '0;
          wr_cnt_d    = '0;
`ifdef BBOX_ROW_PAD4_EN
          in_pad_d    = 1'b0;
          pad_left_d  = '0;
`endif
        end
      end

      ST_SCAN: begin
        rd_addr_c   = scan_addr_q;
        scan_addr_d = scan_addr_q + ADDR_W'(1);
        if (scan_x_q == LAST_X) begin
          scan_x_d = '0;
          if (scan_y_q == LAST_Y) state_d = ST_SCAN_DRAIN;
          else                    scan_y_d = scan_y_q + coord_t'(1);
        end else begin
          scan_x_d = scan_x_q + coord_t'(1);
        end
      end

      ST_SCAN_DRAIN: begin
        state_d = found_now ? ST_COPY : ST_DONE;
      end

      ST_COPY: begin
        // Every COPY cycle produces exactly one write one cycle later,
        // either a copied pixel or a pad word.
        wvld_d = 1'b1;
`ifdef BBOX_ROW_PAD4_EN
        wpad_d = in_pad_q;
        if (in_pad_q) begin
          pad_left_d = pad_left_q - 2'd1;
          if (pad_left_q == 2'd1) begin
            in_pad_d = 1'b0;
            row_done = 1'b1;
          end
        end else if (ox_q == bw) begin
          rd_addr_c = copy_addr;
          ox_d      = '0;
          if (row_pads != 2'd0) begin
            in_pad_d   = 1'b1;
            pad_left_d = row_pads;
          end else begin
            row_done = 1'b1;
          end
        end else begin
          rd_addr_c = copy_addr;
          ox_d      = ox_q + coord_t'(1);
        end
`else
        rd_addr_c = copy_addr;
        if (ox_q == bw) begin
          ox_d     = '0;
          row_done = 1'b1;
        end else begin
          ox_d = ox_q + coord_t'(1);
        end
`endif
        if (row_done) begin
          if (oy_q == bh) state_d = ST_COPY_DRAIN;
          else            oy_d    = oy_q + coord_t'(1);
        end
      end

      ST_COPY_DRAIN: begin
        state_d = ST_DONE;
      end

      ST_DONE: begin
        // Terminal until reset; start is ignored here.
        state_d = ST_DONE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      scan_addr_q <= '0;
      scan_x_q    <= '0;
      scan_y_q    <= '0;
      pvld_q      <= 1'b0;
      px_q        <= '0;
      py_q        <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      wvld_q      <= 1'b0;
      wr_cnt_q    <= '0;
`ifdef BBOX_ROW_PAD4_EN
      in_pad_q    <= 1'b0;
      pad_left_q  <= '0;
      wpad_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      scan_addr_q <= scan_addr_d;
      scan_x_q    <= scan_x_d;
      scan_y_q    <= scan_y_d;
      pvld_q      <= (state_q == ST_SCAN);
      px_q        <= scan_x_q;
      py_q        <= scan_y_q;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      wvld_q      <= wvld_d;
      wr_cnt_q    <= wr_cnt_d;
`ifdef BBOX_ROW_PAD4_EN
      in_pad_q    <= in_pad_d;
      pad_left_q  <= pad_left_d;
      wpad_q      <= wpad_d;
`endif
    end
  end

  assign rd_addr   = rd_addr_c;
  assign wr_en     = wvld_q;
  assign wr_addr   = wvld_q ? wr_cnt_q[ADDR_W-1:0] : '0;
  assign wr_data   = (wvld_q && !wr_is_pad) ? rd_data : '0;
  assign busy      = (state_q == ST_SCAN) || (state_q == ST_SCAN_DRAIN) ||
                     (state_q == ST_COPY) || (state_q == ST_COPY_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign empty     = done && !found;
  assign crop_w    = (done && found) ? CW_W'(bw + coord_t'(1)) : '0;
  assign crop_h    = (done && found) ? CH_W'(bh + coord_t'(1)) : '0;
  assign out_len   = wr_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bbox_crop_engine.sv
// Bench for bbox_crop_engine on an 8x8 frame with background 0xFF.
// Stimulus frames are built directly in a read-memory array; a reference
// model scans that array with plain loops to find the box, and queues the
// expected write words plus the expected run summary. Monitors pop and
// compare independently of the driver.
module tb_bbox_crop_engine;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int N  = W * H;
  localparam int AW = 6;

  typedef struct packed {
    logic        empty;
    logic [3:0]  cw;
    logic [3:0]  ch;
    logic [AW:0] len;
    logic [15:0] lat;
  } res_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          wr_en, busy, done, empty;
  logic [3:0]    crop_w, crop_h;
  logic [AW:0]   out_len;
  logic [2:0]    dbg_state;

  bbox_crop_engine #(
    .IMG_W(W), .IMG_H(H), .PIX_W(8), .BG_VALUE(8'hFF)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .start    (start),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .busy     (busy),
    .done     (done),
    .empty    (empty),
    .crop_w   (crop_w),
    .crop_h   (crop_h),
    .out_len  (out_len),
    .dbg_state(dbg_state)
  );

  // ---------------- memories ----------------
  logic [7:0] rmem [N];
  logic [7:0] wmem [N];

  always @(posedge clk) rd_data <= rmem[rd_addr];
  always @(posedge clk) if (wr_en === 1'b1) wmem[wr_addr] <= wr_data;

  // ---------------- scoreboard state ----------------
  logic [AW+7:0] exp_q[$];
  res_t          res_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int last_len = 0;
  bit mon_en   = 1'b0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("wr_en_known", 64'(wr_en !== 1'b0 && wr_en !== 1'b1), 64'd0);
      if (busy !== 1'b1) check("rd_addr_idle", 64'(rd_addr), 64'd0);
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL wr_unexpected: got write addr %0d data 0x%0h, required no write", wr_addr, wr_data);
        end else begin
          logic [AW+7:0] e;
          e = exp_q.pop_front();
          check("wr_word", 64'({wr_addr, wr_data}), 64'(e));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1 && prev_done !== 1'b1) begin
      if (res_q.size() == 0) begin
        n_checks++;
        $display("FAIL done_unexpected: got done=1, required no completion");
      end else begin
        res_t r;
        r = res_q.pop_front();
        check("empty",   64'(empty),   64'(r.empty));
        check("crop_w",  64'(crop_w),  64'(r.cw));
        check("crop_h",  64'(crop_h),  64'(r.ch));
        check("out_len", 64'(out_len), 64'(r.len));
        check("latency", 64'(cyc - start_cyc), 64'(r.lat));
      end
    end
    prev_done = done;
  end

  // ---------------- reference model ----------------
  task automatic model_frame();
    int mnx, mny, mxx, mxy, w, h, rl, a;
    res_t r;
    mnx = W; mny = H; mxx = -1; mxy = -1;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (rmem[y*W + x] != 8'hFF) begin
          if (x < mnx) mnx = x;
          if (x > mxx) mxx = x;
          if (y < mny) mny = y;
          if (y > mxy) mxy = y;
        end
    if (mxx < 0) begin
      r.empty = 1'b1; r.cw = '0; r.ch = '0; r.len = '0;
      r.lat = 16'(N + 1);
    end else begin
      w  = mxx - mnx + 1;
      h  = mxy - mny + 1;
      rl = w;
`ifdef BBOX_ROW_PAD4_EN
      rl = ((w + 3) / 4) * 4;
`endif
      a = 0;
      for (int y = mny; y <= mxy; y++)
        for (int i = 0; i < rl; i++) begin
          logic [7:0] d;
          d = (i < w) ? rmem[y*W + mnx + i] : 8'h00;
          exp_q.push_back({AW'(a), d});
          a++;
        end
      r.empty = 1'b0; r.cw = 4'(w); r.ch = 4'(h); r.len = (AW+1)'(a);
      r.lat = 16'(N + 1 + a + 1);
    end
    last_len = int'(r.len);
    res_q.push_back(r);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;            // reset must win over a simultaneous start
    repeat (2) @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("reset_state",
          64'({busy, done, empty, wr_en, crop_w, crop_h, out_len, rd_addr, wr_addr, wr_data}),
          64'd0);
  endtask

  task automatic run_frame(input bit pulse_scan, input int abort_after);
    int budget;
    bit aborted;
    do_reset();
    model_frame();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
    budget = 0;
    aborted = 1'b0;
    while (done !== 1'b1 && budget < 2000) begin
      @(negedge clk);
      budget++;
      start = (pulse_scan && budget == 20);
      if (abort_after >= 0 && budget == abort_after) begin
        aborted = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (aborted) begin
      reset = 1'b1;
      @(negedge clk);
      check("abort_outputs", 64'({busy, done, wr_en}), 64'd0);
      reset = 1'b0;
      exp_q.delete();
      res_q.delete();
    end else begin
      check("done_in_budget", 64'(done === 1'b1), 64'd1);
      repeat (2) @(negedge clk);
      check("writes_drained", 64'(exp_q.size()), 64'd0);
      check("result_popped",  64'(res_q.size()), 64'd0);
    end
  endtask

  task automatic fill_bg();
    for (int i = 0; i < N; i++) rmem[i] = 8'hFF;
  endtask

  task automatic fill_square();
    fill_bg();
    for (int y = 3; y <= 5; y++)
      for (int x = 2; x <= 4; x++) rmem[y*W + x] = 8'h00;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int mism;
    reset = 1'b1;
    start = 1'b0;

    // All background: empty result, no writes.
    fill_bg();
    run_frame(1'b0, -1);

    // 3x3 square of 00 at x=2..4, y=3..5.
    fill_square();
    run_frame(1'b0, -1);

    // Single pixel in the last corner.
    fill_bg();
    rmem[N-1] = 8'h40;
    run_frame(1'b0, -1);

    // Full-frame ramp: write memory must mirror read memory.
    for (int i = 0; i < N; i++) rmem[i] = 8'(i);
    run_frame(1'b0, -1);
    mism = 0;
    for (int i = 0; i < N; i++) if (wmem[i] !== rmem[i]) mism++;
    check("full_frame_copy_mismatches", 64'(mism), 64'd0);

    // Reset five cycles into COPY, then rerun the same frame cleanly.
    fill_square();
    run_frame(1'b0, N + 1 + 5);
    run_frame(1'b0, -1);

    // start pulsed mid-SCAN is ignored; start in DONE is ignored too.
    run_frame(1'b1, -1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("done_hold_done",    64'(done),    64'd1);
    check("done_hold_busy",    64'(busy),    64'd0);
    check("done_hold_out_len", 64'(out_len), 64'(last_len));

    // Random sparse frames.
    for (int f = 0; f < 6; f++) begin
      int k;
      fill_bg();
      k = $urandom_range(1, 5);
      for (int j = 0; j < k; j++) rmem[$urandom_range(0, N-1)] = 8'($urandom_range(0, 254));
      run_frame(($urandom_range(0, 1) == 1), -1);
    end

    // Random dense frames (background pixels scattered inside the box).
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < N; i++) rmem[i] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      run_frame(1'b0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule
